// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array controller slice.
//   DEF_N, DEF_DATA_SIZE, DEF_ACC_W : default array size, operand width and
//                                     accumulator width (matches PE out_c)
//   FEED_CYC, DRAIN_CYC             : feed and drain phase lengths for DEF_N
//   ctrl_state_t                    : controller FSM states
//   idx(row, col, n)                : row-major element index into a buffer
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_DATA_SIZE = 4;
  localparam int DEF_ACC_W     = 2 * DEF_DATA_SIZE + 1;

  // A full skewed wavefront needs 2N-1 steps; N more let it ripple to PE(N-1,N-1)
  localparam int FEED_CYC  = 2 * DEF_N - 1;
  localparam int DRAIN_CYC = DEF_N;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE
  } ctrl_state_t;

  function automatic int idx(input int row, input int col, input int n = DEF_N);
    return row * n + col;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// Produces the registered, diagonally skewed edge operands for the array.
// On a load step t, row i receives A[i][t-i] and column j receives B[t-j][j]
// whenever that index lies inside the matrix; everything else is zero.
//   clk, reset  : clock, asynchronous active-high reset
//   load_i      : a feed step is to be presented on the next cycle
//   step_i      : that feed step t
//   a_buf_i     : A buffer, element row*N+col
//   b_buf_i     : B buffer, element row*N+col
//   arr_a_o     : left-edge operands, slice i = row i
//   arr_b_o     : top-edge operands, slice j = column j
// -----------------------------------------------------------------------------
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int STEP_W    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_i,
  input  logic [STEP_W-1:0]             step_i,
  input  logic [N*N*DATA_SIZE-1:0]      a_buf_i,
  input  logic [N*N*DATA_SIZE-1:0]      b_buf_i,
  output logic [N*DATA_SIZE-1:0]        arr_a_o,
  output logic [N*DATA_SIZE-1:0]        arr_b_o
);

  localparam int AW = $clog2(N * N);

  logic [N*N-1:0][DATA_SIZE-1:0] a_mem;
  logic [N*N-1:0][DATA_SIZE-1:0] b_mem;
  logic [N-1:0][DATA_SIZE-1:0]   a_d, b_d;
  logic [N-1:0][DATA_SIZE-1:0]   a_q, b_q;

  assign a_mem = a_buf_i;
  assign b_mem = b_buf_i;

  // Row i and column i share the same validity window (0 <= t-i < N)
  always_comb begin
    a_d = '0;
    b_d = '0;
    if (load_i) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(step_i) >= i) && ((int'(step_i) - i) < N)) begin
          a_d[i] = a_mem[AW'(idx(i, int'(step_i) - i, N))];
          b_d[i] = b_mem[AW'(idx(int'(step_i) - i, i, N))];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign arr_a_o = a_q;
  assign arr_b_o = b_q;

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for an N x N output-stationary systolic array. Buffers host-written
// A and B, and on start runs CLEAR -> FEED -> DRAIN -> CAPTURE, copying every
// PE accumulator into the result buffer and pulsing done.
//   clk, reset           : clock, asynchronous active-high reset
//   start                : job request, honoured only in IDLE
//   busy, done           : job in progress / one-cycle result-valid pulse
//   a_wr_en, b_wr_en     : host writes into A / B (IDLE only)
//   wr_addr, wr_data     : element index row*N+col and value
//   arr_clr              : synchronous clear to the PE array
//   arr_a, arr_b         : skewed left / top edge operands
//   arr_c                : PE accumulators, slice i*N+j
//   c_rd_addr, c_rd_data : combinational result buffer read
// Optional: define SYSTOLIC_CTRL_PERF_EN to add perf_jobs (completed jobs)
// and perf_busy_cyc (cycles with busy high); both wrap.
// -----------------------------------------------------------------------------
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int DATA_SIZE = DEF_DATA_SIZE,
  parameter  int ACC_W     = 2 * DATA_SIZE + 1,
  localparam int AW        = $clog2(N * N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     a_wr_en,
  input  logic                     b_wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_SIZE-1:0]     wr_data,
  output logic                     arr_clr,
  output logic [N*DATA_SIZE-1:0]   arr_a,
  output logic [N*DATA_SIZE-1:0]   arr_b,
  input  logic [N*N*ACC_W-1:0]     arr_c,
  input  logic [AW-1:0]            c_rd_addr,
  output logic [ACC_W-1:0]         c_rd_data
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]              perf_jobs,
  output logic [31:0]              perf_busy_cyc
`endif
);

  // Phase lengths scale with N around the package defaults
  localparam int FEED_LEN  = FEED_CYC + 2 * (N - DEF_N);
  localparam int DRAIN_LEN = DRAIN_CYC + (N - DEF_N);
  localparam int CNT_W     = $clog2(FEED_LEN + 1);

  ctrl_state_t                   state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          busy_q, done_q, clr_q;
  logic [N*N-1:0][DATA_SIZE-1:0] a_buf_q, b_buf_q;
  logic [N*N-1:0][ACC_W-1:0]     c_buf_q;

  logic                          feed_load_d;
  logic [CNT_W-1:0]              feed_step_d;

  // Feeder registers its outputs, so it is told one cycle ahead which step
  // will be on the array edge: step 0 while in CLEAR, then cnt+1 during FEED.
  always_comb begin
    feed_load_d = 1'b0;
    feed_step_d = '0;
    if (state_q == CLEAR) begin
      feed_load_d = 1'b1;
    end else if ((state_q == FEED) && (cnt_q != CNT_W'(FEED_LEN - 1))) begin
      feed_load_d = 1'b1;
      feed_step_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      a_buf_q <= '0;
      b_buf_q <= '0;
      c_buf_q <= '0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_wr_en) a_buf_q[wr_addr] <= wr_data;
          if (b_wr_en) b_buf_q[wr_addr] <= wr_data;
          if (start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= FEED;
          cnt_q   <= '0;
        end
        FEED: begin
          if (cnt_q == CNT_W'(FEED_LEN - 1)) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
            state_q <= CAPTURE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CAPTURE: begin
          c_buf_q <= arr_c;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  systolic_skew_feeder #(
    .N        (N),
    .DATA_SIZE(DATA_SIZE),
    .STEP_W   (CNT_W)
  ) u_feeder (
    .clk    (clk),
    .reset  (reset),
    .load_i (feed_load_d),
    .step_i (feed_step_d),
    .a_buf_i(a_buf_q),
    .b_buf_i(b_buf_q),
    .arr_a_o(arr_a),
    .arr_b_o(arr_b)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign arr_clr   = clr_q;
  assign c_rd_data = c_buf_q[c_rd_addr];

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] perf_jobs_q;
  logic [31:0] perf_busy_cyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_jobs_q     <= '0;
      perf_busy_cyc_q <= '0;
    end else begin
      if (done_q) perf_jobs_q <= perf_jobs_q + 16'd1;
      if (busy_q) perf_busy_cyc_q <= perf_busy_cyc_q + 32'd1;
    end
  end

  assign perf_jobs     = perf_jobs_q;
  assign perf_busy_cyc = perf_busy_cyc_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
// Directed bench for systolic_ctrl. A behavioural N x N output-stationary PE
// array is wired to the controller so the captured results are real products.
// Build with SYSTOLIC_CTRL_PERF_EN defined to also exercise the perf counters.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int N     = DEF_N;
  localparam int DS    = DEF_DATA_SIZE;
  localparam int ACC_W = DEF_ACC_W;
  localparam int AW    = $clog2(N * N);
  localparam int RUN   = 40;

  logic                 clk, reset, start, busy, done;
  logic                 a_wr_en, b_wr_en, arr_clr;
  logic [AW-1:0]        wr_addr, c_rd_addr;
  logic [DS-1:0]        wr_data;
  logic [N*DS-1:0]      arr_a, arr_b;
  logic [N*N*ACC_W-1:0] arr_c;
  logic [ACC_W-1:0]     c_rd_data;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0]          perf_jobs;
  logic [31:0]          perf_busy_cyc;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [N*DS-1:0]  snapA   [0:RUN];
  logic [N*DS-1:0]  snapB   [0:RUN];
  logic [ACC_W-1:0] snapC   [0:RUN];
  logic             snapClr [0:RUN];

  systolic_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .a_wr_en      (a_wr_en),
    .b_wr_en      (b_wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .arr_clr      (arr_clr),
    .arr_a        (arr_a),
    .arr_b        (arr_b),
    .arr_c        (arr_c),
    .c_rd_addr    (c_rd_addr),
    .c_rd_data    (c_rd_data)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_jobs    (perf_jobs),
    .perf_busy_cyc(perf_busy_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE array: a moves right, b moves down, acc wraps at ACC_W bits
  logic [N*N-1:0][DS-1:0]    peA, peB;
  logic [N*N-1:0][ACC_W-1:0] peAcc;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [DS-1:0] ain, bin;
        ain = arr_a[i*DS +: DS];
        bin = arr_b[j*DS +: DS];
        if (j > 0) ain = peA[i*N + j - 1];
        if (i > 0) bin = peB[(i-1)*N + j];
        if (arr_clr) begin
          peAcc[i*N+j] <= '0;
          peA[i*N+j]   <= '0;
          peB[i*N+j]   <= '0;
        end else begin
          peAcc[i*N+j] <= peAcc[i*N+j] + ACC_W'(ain) * ACC_W'(bin);
          peA[i*N+j]   <= ain;
          peB[i*N+j]   <= bin;
        end
      end
    end
  end

  assign arr_c = peAcc;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeElem(input logic aEn, input logic bEn, input int addr,
                           input int data);
    @(negedge clk);
    a_wr_en = aEn;
    b_wr_en = bEn;
    wr_addr = AW'(addr);
    wr_data = DS'(data);
    @(negedge clk);
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  // A = identity, B[r][c] = r*4+c
  task automatic loadIdentityRamp();
    for (int k = 0; k < N*N; k++) begin
      writeElem(1'b1, 1'b0, k, ((k / N) == (k % N)) ? 1 : 0);
      writeElem(1'b0, 1'b1, k, k);
    end
  endtask

  task automatic readCheck(input string tag, input int addr, input int expected);
    c_rd_addr = AW'(addr);
    #1;
    checkOutput(tag, 32'(c_rd_data), expected);
  endtask

  // Runs RUN cycles from a start in cycle 0, recording per-cycle outputs.
  // start is also driven in cycles pulseA/pulseB and in every cycle <= holdUntil;
  // an A[0][0]=7 write is attempted in cycle wrCyc.
  task automatic applyStimulus(input int pulseA, input int pulseB, input int wrCyc,
                               input int holdUntil, output int firstDone,
                               output int lastDone, output int busyCnt,
                               output int doneCnt);
    firstDone = -1;
    lastDone  = -1;
    busyCnt   = 0;
    doneCnt   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= RUN; c++) begin
      tick();
      snapA[c]   = arr_a;
      snapB[c]   = arr_b;
      snapC[c]   = c_rd_data;
      snapClr[c] = arr_clr;
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (firstDone < 0) firstDone = c;
        lastDone = c;
      end
      start   = (c == pulseA) || (c == pulseB) || (c <= holdUntil);
      a_wr_en = (c == wrCyc);
      wr_addr = '0;
      wr_data = DS'(7);
    end
    start   = 1'b0;
    a_wr_en = 1'b0;
  endtask

  initial begin
    int fd, ld, bc, dc, idleDone;
    reset     = 1'b1;
    start     = 1'b0;
    a_wr_en   = 1'b0;
    b_wr_en   = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    c_rd_addr = '0;
    #12;
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst done", 32'(done), 0);
    checkOutput("rst arr_clr", 32'(arr_clr), 0);
    checkOutput("rst arr_a", 32'(arr_a), 0);
    checkOutput("rst arr_b", 32'(arr_b), 0);
    readCheck("rst C[0]", 0, 0);

    $display("[TB] test 1: identity x ramp");
    loadIdentityRamp();
    applyStimulus(-1, -1, -1, 0, fd, ld, bc, dc);
    checkOutput("t1 done cycle", 32'(fd), 14);
    checkOutput("t1 done count", 32'(dc), 1);
    checkOutput("t1 busy width", 32'(bc), 13);
    checkOutput("t1 clr cyc1", 32'(snapClr[1]), 1);
    checkOutput("t1 clr cyc2", 32'(snapClr[2]), 0);
    checkOutput("t1 arr_a cyc1", 32'(snapA[1]), 0);
    checkOutput("t1 arr_a t0", 32'(snapA[2]), 32'h0001);
    checkOutput("t1 arr_b t1", 32'(snapB[3]), 32'h0014);
    checkOutput("t1 arr_a t2", 32'(snapA[4]), 32'h0010);
    checkOutput("t1 arr_b t2", 32'(snapB[4]), 32'h0258);
    checkOutput("t1 arr_a t6", 32'(snapA[8]), 32'h1000);
    checkOutput("t1 arr_b t6", 32'(snapB[8]), 32'hF000);
    checkOutput("t1 arr_a drain", 32'(snapA[9]), 0);
    checkOutput("t1 arr_b drain", 32'(snapB[9]), 0);
    for (int k = 0; k < N*N; k++) readCheck($sformatf("t1 C[%0d]", k), k, k);

    $display("[TB] test 2: all 15, wrap");
    for (int k = 0; k < N*N; k++) writeElem(1'b1, 1'b1, k, 15);
    applyStimulus(-1, -1, -1, 0, fd, ld, bc, dc);
    checkOutput("t2 done cycle", 32'(fd), 14);
    for (int k = 0; k < N*N; k++) readCheck($sformatf("t2 C[%0d]", k), k, 388);

    $display("[TB] test 3: start while busy");
    applyStimulus(3, 10, -1, 0, fd, ld, bc, dc);
    checkOutput("t3 done cycle", 32'(fd), 14);
    checkOutput("t3 done count", 32'(dc), 1);
    checkOutput("t3 busy width", 32'(bc), 13);
    readCheck("t3 C[5]", 5, 388);

    $display("[TB] test 4: write during job");
    loadIdentityRamp();
    applyStimulus(-1, -1, 4, 0, fd, ld, bc, dc);
    checkOutput("t4a done cycle", 32'(fd), 14);
    readCheck("t4a C[0][1]", 1, 1);
    readCheck("t4a C[0][3]", 3, 3);
    writeElem(1'b1, 1'b0, 0, 7);
    c_rd_addr = AW'(1);
    applyStimulus(-1, -1, -1, 0, fd, ld, bc, dc);
    checkOutput("t4b C read in CAPTURE", 32'(snapC[13]), 1);
    checkOutput("t4b C read at done", 32'(snapC[14]), 7);
    readCheck("t4b C[0][3]", 3, 21);
    readCheck("t4b C[1][1]", 5, 5);

    $display("[TB] test 5: reset during FEED");
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("t5 busy before reset", 32'(busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("t5 busy", 32'(busy), 0);
    checkOutput("t5 done", 32'(done), 0);
    checkOutput("t5 arr_a", 32'(arr_a), 0);
    checkOutput("t5 arr_b", 32'(arr_b), 0);
    checkOutput("t5 arr_clr", 32'(arr_clr), 0);
    for (int k = 0; k < N*N; k++) readCheck($sformatf("t5 C[%0d]", k), k, 0);
    @(negedge clk);
    reset = 1'b0;
    idleDone = 0;
    repeat (20) begin
      tick();
      if (done) idleDone++;
    end
    checkOutput("t5 no done after reset", 32'(idleDone), 0);
    loadIdentityRamp();
    applyStimulus(-1, -1, -1, 0, fd, ld, bc, dc);
    checkOutput("t5 rerun done cycle", 32'(fd), 14);
    readCheck("t5 rerun C[2][3]", 11, 11);
    readCheck("t5 rerun C[0][1]", 1, 1);
    readCheck("t5 rerun C[3][0]", 12, 12);

    $display("[TB] test 6: start held across done");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    loadIdentityRamp();
    applyStimulus(-1, -1, -1, 14, fd, ld, bc, dc);
    checkOutput("t6 first done", 32'(fd), 14);
    checkOutput("t6 second done", 32'(ld), 28);
    checkOutput("t6 done count", 32'(dc), 2);
    checkOutput("t6 busy cycles", 32'(bc), 26);
    readCheck("t6 C[2][3]", 11, 11);
`ifdef SYSTOLIC_CTRL_PERF_EN
    checkOutput("t6 perf_jobs", 32'(perf_jobs), 2);
    checkOutput("t6 perf_busy_cyc", perf_busy_cyc, 26);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of `pe` instances. Each PE has a 4-bit LUT multiplier, a synchronous-clear accumulator `out_c`, and forwards operands right (a) and down (b).
- The block buffers matrices A and B written by the host. On `start` it clears the array, streams skewed operands into the left and top edges, waits for drain, snapshots all N*N accumulators into a result buffer, and pulses `done`.
- It sits between the host register interface and the array top level.

Parameters:
N, 4, array dimension (rows = cols)
DATA_SIZE, 4, operand width (matches PE)
ACC_W, 2*DATA_SIZE+1, accumulator width (matches PE out_c)
AW, $clog2(N*N), buffer address width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous active-high
start  in  1  job request, sampled in IDLE only
busy  out  1  high from CLEAR through CAPTURE
done  out  1  one-cycle pulse, result buffer valid
a_wr_en  in  1  write A element
b_wr_en  in  1  write B element
wr_addr  in  AW  element index row*N+col (shared by A/B)
wr_data  in  DATA_SIZE  element value
arr_clr  out  1  drives PE reset pins (sync clear)
arr_a  out  N*DATA_SIZE  left-edge operands, slice i = row i
arr_b  out  N*DATA_SIZE  top-edge operands, slice j = column j
arr_c  in  N*N*ACC_W  PE out_c, slice i*N+j
c_rd_addr  in  AW  result index row*N+col
c_rd_data  out  ACC_W  combinational read of result buffer

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, arr_clr=0; arr_a, arr_b=0; counters=0; A, B and C buffers=0.
- FSM: IDLE -> CLEAR -> FEED -> DRAIN -> CAPTURE -> IDLE.
- IDLE: `start`=1 moves to CLEAR next cycle. A/B writes are accepted; if both `a_wr_en` and `b_wr_en` are set, both buffers are written.
- CLEAR: 1 cycle, `arr_clr`=1, operands 0.
- FEED: 2N-1 cycles, step counter t=0..2N-2.
  - All operands are registered outputs.
  - `arr_a` row i = A[i][t-i] when 0<=t-i<N, else 0.
  - `arr_b` col j = B[t-j][j] when 0<=t-j<N, else 0.
- DRAIN: N cycles, operands 0, lets the last product reach PE(N-1,N-1).
- CAPTURE: 1 cycle, C[k] <= arr_c slice k for all k.
- `done`=1 in the cycle after CAPTURE, with state=IDLE.
- Latency: if `start` is sampled in cycle 0, `done` is high in cycle 3N+2 (14 for N=4).
- `start` while busy: ignored, not queued.
- `start` in the `done` cycle: accepted, with the new CLEAR next cycle.
- A/B writes while busy: dropped. The job uses a stable snapshot.
- C buffer changes only in CAPTURE. Reads during a job return the previous result.
- Arithmetic: no saturation. Results wrap modulo 2^ACC_W exactly as the PE accumulator does; the controller copies them unmodified.
- Reset mid-job: immediate return to IDLE with no `done`. Buffers are zeroed; the array is cleared by the next job's CLEAR.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_EN.
- Defined: adds outputs `perf_jobs` [15:0] and `perf_busy_cyc` [31:0].
  - `perf_jobs` increments on each `done`.
  - `perf_busy_cyc` increments each cycle `busy`=1.
  - Both wrap, and both clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `systolic_pkg`:
  - N, DATA_SIZE, ACC_W defaults.
  - State enum `ctrl_state_t` {IDLE, CLEAR, FEED, DRAIN, CAPTURE}.
  - Constants FEED_CYC=2N-1, DRAIN_CYC=N.
  - Function `idx(row,col)`.
- Sub-module `systolic_skew_feeder`:
  - Inputs: buffer contents plus step t.
  - Outputs: registered skewed `arr_a`/`arr_b` edge vectors.
  - Instantiated once; the FSM and buffers stay in the top.

Test Plan:
1. N=4, A=identity, B[r][c]=r*4+c, start -> `done` at cycle 14; C equals B for all 16 elements, e.g. C[2][3]=11.
2. A=B=all 15 -> every C = 4*225 mod 512 = 388, confirming wrap is preserved.
3. Pulse `start` again at cycles 3 and 10 of a job -> ignored; exactly one `done`; busy width 13 cycles.
4. Write A[0][0]=7 during FEED -> result uses the old value; a second job after `done` uses 7.
5. Assert reset during FEED (t=3) -> busy, done, arr_a, arr_b = 0 immediately; c_rd_data=0 everywhere; a following full job gives correct results.
6. `start` held high across `done` -> back-to-back jobs, second `done` 3N+2 cycles after the first; with SYSTOLIC_CTRL_PERF_EN, perf_jobs=2 and perf_busy_cyc=26.
